// File: rtl/fusion_unit.sv
// fusion_unit: multi-precision dot-product accumulator built from 16 fused 2x2-bit signed bricks
module fusion_unit #(
   parameter int ACC_W = 32,
   parameter int SAT   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      a,
   input  logic [31:0]      b,
   input  logic             sa,
   input  logic             sb,
   input  logic [1:0]       mode,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data
);
   localparam int XW = 50;
   localparam logic signed [XW-1:0] L_MAX = (50'sd1 <<< (ACC_W - 1)) - 50'sd1;
   localparam logic signed [XW-1:0] L_MIN = -L_MAX - 50'sd1;
   logic                    w_adv;
   logic                    r_v0, r_l0, r_sa, r_sb;
   logic [1:0]              r_m0;
   logic [31:0]             r_a, r_b;
   logic                    r_v1, r_l1;
   logic [1:0]              r_m1;
   logic signed [5:0]       r_pp [16];
   logic signed [5:0]       w_pp [16];
   logic [17:0]             w_beat;
   logic signed [XW-1:0]    w_full;
   logic [ACC_W-1:0]        r_acc, w_acc_nx, r_out;
   logic                    r_ov;
   assign w_adv     = !r_ov || out_ready;
   assign in_ready  = w_adv;
   assign out_valid = r_ov;
   assign out_data  = r_out;
   // Only the top slice of each element carries the sign; lower slices are unsigned magnitude bits.
   for (genvar k = 0; k < 16; k++) begin : g_brick
      localparam int P4 = (k >> 1) & 1, Q4 = k & 1, E4 = k >> 2, P8 = k >> 2, Q8 = k & 3;
      logic [1:0]        w_as, w_bs;
      logic              w_fa, w_fb;
      logic signed [2:0] w_xa, w_xb;
      logic signed [5:0] w_pr;
      assign w_as  = r_m0 == 2'd0 ? r_a[2*k+:2] : r_m0 == 2'd1 ? r_a[4*E4+2*P4+:2] : r_a[2*P8+:2];
      assign w_bs  = r_m0 == 2'd0 ? r_b[2*k+:2] : r_m0 == 2'd1 ? r_b[4*E4+2*Q4+:2] : r_b[2*Q8+:2];
      assign w_fa  = r_m0 == 2'd0 ? r_sa : r_m0 == 2'd1 ? (r_sa && P4 == 1) : (r_sa && P8 == 3);
      assign w_fb  = r_m0 == 2'd0 ? r_sb : r_m0 == 2'd1 ? (r_sb && Q4 == 1) : (r_sb && Q8 == 3);
      assign w_xa  = {w_as[1] & w_fa, w_as};
      assign w_xb  = {w_bs[1] & w_fb, w_bs};
      assign w_pr  = w_xa * w_xb;
      assign w_pp[k] = r_m0 == 2'd3 ? '0 : w_pr;
   end
   always_comb begin
      w_beat = '0;
      for (int k = 0; k < 16; k++)
         w_beat = w_beat + ({{12{r_pp[k][5]}}, r_pp[k]} << (r_m1 == 2'd1 ? 2 * (((k >> 1) & 1) + (k & 1)) :
                                                              r_m1 == 2'd2 ? 2 * ((k >> 2) + (k & 3)) : 0));
      w_full   = {{(XW-ACC_W){r_acc[ACC_W-1]}}, r_acc} + {{(XW-18){w_beat[17]}}, w_beat};
      w_acc_nx = (SAT != 0 && w_full > L_MAX) ? L_MAX[ACC_W-1:0] :
                 (SAT != 0 && w_full < L_MIN) ? L_MIN[ACC_W-1:0] : w_full[ACC_W-1:0];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v0  <= 1'b0;
         r_v1  <= 1'b0;
         r_ov  <= 1'b0;
         r_out <= '0;
         r_acc <= '0;
      end else if (w_adv) begin
         r_v0  <= in_valid;
         r_a   <= a;
         r_b   <= b;
         r_sa  <= sa;
         r_sb  <= sb;
         r_m0  <= mode;
         r_l0  <= in_last;
         r_v1  <= r_v0;
         r_m1  <= r_m0;
         r_l1  <= r_l0;
         r_pp  <= w_pp;
         r_ov  <= r_v1 && r_l1;
         if (r_v1 && r_l1) r_out <= w_acc_nx;
         if (r_v1) r_acc <= r_l1 ? '0 : w_acc_nx;
      end
   end
endmodule

// File: tb/tb_fusion_unit.sv
// tb_fusion_unit: vector table plus scoreboard against an element-level dot-product model
module tb_fusion_unit;
   logic        clk = 1'b0, rst, in_valid, sa, sb, in_last, out_ready;
   logic [31:0] a, b;
   logic [1:0]  mode;
   logic        in_ready, out_valid, rdy_s, ov_s, rdy_w, ov_w;
   logic [31:0] d32;
   logic [15:0] d16s, d16w;
   typedef struct { logic [1:0] m; logic [31:0] a, b; logic sa, sb, last; logic [31:0] exp; } vec_t;
   typedef struct { logic [31:0] e32; logic [15:0] es, ew; } exp_t;
   vec_t   tbl [14];
   exp_t   q [$];
   longint m32 = 0, m16s = 0, m16w = 0;
   int     n_tests = 0, n_fail = 0, n_hs = 0, cyc = 0;

   fusion_unit dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .sa(sa), .sb(sb), .mode(mode), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(d32));
   fusion_unit #(.ACC_W(16), .SAT(1)) dut_s (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .a(a), .b(b),
      .sa(sa), .sb(sb), .mode(mode), .in_last(in_last), .out_valid(ov_s), .out_ready(out_ready), .out_data(d16s));
   fusion_unit #(.ACC_W(16), .SAT(0)) dut_w (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w), .a(a), .b(b),
      .sa(sa), .sb(sb), .mode(mode), .in_last(in_last), .out_valid(ov_w), .out_ready(out_ready), .out_data(d16w));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic longint beat_sum(input logic [31:0] x, y, input logic s_a, s_b, input logic [1:0] m);
      longint s = 0;
      int w = m == 2'd0 ? 2 : m == 2'd1 ? 4 : 8;
      int n = m == 2'd0 ? 16 : m == 2'd1 ? 4 : m == 2'd2 ? 1 : 0;
      for (int i = 0; i < n; i++) begin
         longint ea = longint'((x >> (w * i)) & ((32'd1 << w) - 1));
         longint eb = longint'((y >> (w * i)) & ((32'd1 << w) - 1));
         if (s_a && ea >= (longint'(1) << (w - 1))) ea -= longint'(1) << w;
         if (s_b && eb >= (longint'(1) << (w - 1))) eb -= longint'(1) << w;
         s += ea * eb;
      end
      return s;
   endfunction

   function automatic longint acc_add(input longint acc, bs, input int w, input bit sat);
      longint f = acc + bs;
      longint mx = (longint'(1) << (w - 1)) - 1;
      longint mn = -mx - 1;
      if (sat) return f > mx ? mx : f < mn ? mn : f;
      f = f & ((longint'(1) << w) - 1);
      if (f > mx) f -= longint'(1) << w;
      return f;
   endfunction

   task automatic send(input logic [1:0] m, input logic [31:0] x, y, input logic s_a, s_b, last,
                       input logic [31:0] e32, input bit use_e);
      bit got = 0;
      int t = 0;
      longint bs;
      in_valid = 1'b1; a = x; b = y; sa = s_a; sb = s_b; mode = m; in_last = last;
      while (!got && t < 200) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
         t++;
         if (!got) out_ready = 1'b1;
      end
      in_valid = 1'b0;
      if (!got) begin
         chk("accept_timeout", 32'd0, 32'd1);
         return;
      end
      bs   = beat_sum(x, y, s_a, s_b, m);
      m32  = acc_add(m32, bs, 32, 1'b0);
      m16s = acc_add(m16s, bs, 16, 1'b1);
      m16w = acc_add(m16w, bs, 16, 1'b0);
      if (last) begin
         q.push_back('{use_e ? e32 : m32[31:0], m16s[15:0], m16w[15:0]});
         m32 = 0; m16s = 0; m16w = 0;
      end
   endtask

   task automatic drain();
      int t = 0;
      out_ready = 1'b1;
      while ((q.size() != 0 || out_valid) && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("drain_left", q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         exp_t e;
         n_hs++;
         if (q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
         else begin
            e = q.pop_front();
            chk("result32", d32, e.e32);
            chk("result16_sat", {16'd0, d16s}, {16'd0, e.es});
            chk("result16_wrap", {16'd0, d16w}, {16'd0, e.ew});
            chk("valid_agree", {30'd0, ov_s, ov_w}, 32'd3);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int h0, t0;
      tbl = '{
         '{2'd2, 32'h000000FF, 32'h00000002, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFE},
         '{2'd2, 32'h000000FF, 32'h00000002, 1'b0, 1'b0, 1'b1, 32'd510},
         '{2'd0, 32'hFFFFFFFF, 32'h55555555, 1'b1, 1'b1, 1'b1, 32'hFFFFFFF0},
         '{2'd1, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 1'b1, 32'd900},
         '{2'd1, 32'hABCDFFFF, 32'hABCDFFFF, 1'b0, 1'b0, 1'b1, 32'd900},
         '{2'd2, 32'h00000005, 32'h00000005, 1'b0, 1'b0, 1'b0, 32'd0},
         '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'd25},
         '{2'd1, 32'h000000F9, 32'h00000023, 1'b1, 1'b0, 1'b1, 32'hFFFFFFE9},
         '{2'd0, 32'h0000000E, 32'h0000000F, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFB},
         '{2'd2, 32'h00000080, 32'h00000080, 1'b1, 1'b1, 1'b0, 32'd0},
         '{2'd2, 32'h00000080, 32'h00000080, 1'b1, 1'b1, 1'b1, 32'd32768},
         '{2'd0, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'd0},
         '{2'd1, 32'h00000007, 32'h00000007, 1'b0, 1'b0, 1'b0, 32'd0},
         '{2'd2, 32'h00000081, 32'h00000003, 1'b1, 1'b0, 1'b1, 32'hFFFFFEB5}};
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sa = 1'b0; sb = 1'b0; mode = 2'd0; in_last = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", d32, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      send(2'd2, 32'd3, 32'd3, 1'b0, 1'b0, 1'b1, 32'd9, 1'b1);
      chk("lat_e0", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      chk("lat_e1", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      chk("lat_e2", {31'd0, out_valid}, 32'd1);
      t0 = cyc;
      for (int i = 0; i < 14; i++)
         send(tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].sa, tbl[i].sb, tbl[i].last, tbl[i].exp, 1'b1);
      chk("throughput_cycles", cyc - t0, 14);
      drain();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(2'd2, 32'd10, 32'd10, 1'b0, 1'b0, i == 2, 32'd300, 1'b1);
      for (int t = 0; t < 10 && !out_valid; t++) begin
         @(posedge clk); #1;
      end
      h0 = n_hs;
      for (int i = 0; i < 3; i++) begin
         chk("stall_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_data", d32, 32'd300);
         chk("stall_in_ready", {30'd0, in_ready, rdy_s}, 32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_hs_once", n_hs - h0, 1);
      chk("stall_valid_clear", {31'd0, out_valid}, 32'd0);
      repeat (3) @(posedge clk);
      #1 chk("stall_hs_total", n_hs - h0, 1);
      send(2'd2, 32'd10, 32'd10, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      send(2'd2, 32'd10, 32'd10, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      m32 = 0; m16s = 0; m16w = 0;
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst_valid", {31'd0, out_valid}, 32'd0);
      send(2'd2, 32'd3, 32'd3, 1'b0, 1'b0, 1'b1, 32'd9, 1'b1);
      drain();
      for (int i = 0; i < 40; i++) begin
         out_ready = $urandom_range(0, 3) != 0;
         send(2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              i == 39 || $urandom_range(0, 3) == 0, 32'd0, 1'b0);
      end
      drain();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fusion_unit.md
FUSION_UNIT -- requirements
Module: fusion_unit

Interface
REQ-001 Parameter ACC_W, default 32: accumulator and result width in bits, legal range 16..48.
REQ-002 Parameter SAT, default 0: 0 = accumulator wraps modulo 2^ACC_W; 1 = accumulator saturates at signed bounds.
REQ-003 Port clk  input  1: single clock, all state updates on rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port in_valid  input  1: input beat present.
REQ-006 Port in_ready  output  1: block accepts beat this cycle.
REQ-007 Port a  input  32: packed operand A elements.
REQ-008 Port b  input  32: packed operand B elements.
REQ-009 Port sa  input  1: 1 = A elements signed two's complement, 0 = unsigned.
REQ-010 Port sb  input  1: 1 = B elements signed, 0 = unsigned.
REQ-011 Port mode  input  2: element precision; 00 = 2-bit, 01 = 4-bit, 10 = 8-bit, 11 = reserved.
REQ-012 Port in_last  input  1: beat closes the current dot product.
REQ-013 Port out_valid  output  1: result available.
REQ-014 Port out_ready  input  1: consumer accepts result.
REQ-015 Port out_data  output  ACC_W: completed dot-product result, signed two's complement.

Function
REQ-016 Beat accepted when in_valid && in_ready; a, b, sa, sb, mode, in_last sampled together.
REQ-017 Core = 16 2x2-bit bit-bricks, each extending its 2-bit slices to 3 bits, MSB = slice bit 1 AND its sign flag; bricks fuse with shift-add to form wider products.
REQ-018 Mode 00: 16 products a[2i+1:2i]*b[2i+1:2i], i=0..15; beat sum = sum of all 16.
REQ-019 Mode 01: 4 products a[4i+3:4i]*b[4i+3:4i], i=0..3; a[31:16], b[31:16] ignored.
REQ-020 Mode 10: 1 product a[7:0]*b[7:0]; a[31:8], b[31:8] ignored.
REQ-021 Mode 11: beat sum = 0; beat otherwise processed normally, including in_last.
REQ-022 Sign of each element is set independently by sa/sb; beat sum sign-extended to ACC_W before accumulation.
REQ-023 Pipeline: stage 1 registers the 16 brick partial products plus mode/last/valid; stage 2 performs shift-add reduction and accumulation.
REQ-024 Advance condition adv = !out_valid || out_ready; in_ready = adv; when adv is low, both stages and accumulator hold.
REQ-025 Stage 2 on valid beat, not last: acc <= acc + beat_sum.
REQ-026 Stage 2 on valid beat with last: out_data <= acc + beat_sum, out_valid <= 1, acc <= 0 in the same edge.
REQ-027 Latency: beat with in_last accepted at edge E; out_valid high after edge E+2, absent stalls.
REQ-028 out_valid clears on the edge where out_valid && out_ready, unless a new last beat completes on that edge, in which case it stays 1 with the new out_data.
REQ-029 out_data and out_valid hold stable while out_valid && !out_ready.
REQ-030 Throughput: one beat per cycle when out_ready held high.
REQ-031 SAT=1: each addition clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; SAT=0: two's-complement wrap.
REQ-032 Mode, sa, sb may differ on every beat within one dot product; each beat uses its own values.
REQ-033 Bubbles (in_valid low) leave acc unchanged.

Reset
REQ-034 On rst: acc=0, out_data=0, out_valid=0, all pipeline valid bits=0; in_ready=1 in the first cycle after reset.
REQ-035 rst mid-dot-product discards partial acc and in-flight beats; no result is emitted for them.

Verification
REQ-036 Mode 10, a=0xFF, b=0x02, sa=sb=1, last -> out_data=0xFFFFFFFE (-2) two cycles later; same with sa=sb=0 -> 510.
REQ-037 Mode 00, a=0xFFFFFFFF, b=0x55555555, sa=sb=1, last -> out_data = -16.
REQ-038 Mode 01, a=b=0x0000FFFF, unsigned, last -> 900; upper halves set to 0xABCD, result unchanged.
REQ-039 Three mode-10 unsigned beats 10*10, last on third, out_ready low 3 cycles -> out_data=300 held stable, in_ready low during stall, one handshake only.
REQ-040 ACC_W=16, SAT=1, two mode-10 signed beats -128*-128 -> 32767; SAT=0 -> 0x8000.
REQ-041 rst asserted after 2 of 3 beats, then one beat 3*3 with last -> out_data=9.
